// File: rtl/keypad_entry.sv
// Keypad entry: turns debounced 3x4 key levels into press events, builds a BCD digit buffer,
// '*' deletes, '#' commits to a valid/ready output; optional idle timeout clears partials.
// Ports: clk, rst_n, en, numbers[9:0], asterisk, hash -> key_pulse, key_code, entry, entry_len,
//        code_valid/code_ready, code, code_len, err, timeout.
module keypad_entry #(
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [9:0]          numbers,
  input  logic                asterisk,
  input  logic                hash,
  output logic                key_pulse,
  output logic [3:0]          key_code,
  output logic [4*DIGITS-1:0] entry,
  output logic [3:0]          entry_len,
  output logic                code_valid,
  input  logic                code_ready,
  output logic [4*DIGITS-1:0] code,
  output logic [3:0]          code_len,
  output logic                err,
  output logic                timeout
);

  localparam int EW = 4 * DIGITS;
  localparam logic [1:0] S_REL = 2'd0;
  localparam logic [1:0] S_PRS = 2'd1;
  localparam logic [1:0] S_INV = 2'd2;
  localparam bit TEN = (TIMEOUT > 0);
  localparam logic [23:0] TLAST =
    (TIMEOUT > 0) ? 24'(TIMEOUT - 1) : 24'd0;

  logic [1:0]    r_state;
  logic [23:0]   r_cnt;
  logic          r_key_pulse;
  logic [3:0]    r_key_code;
  logic [EW-1:0] r_entry;
  logic [3:0]    r_len;
  logic          r_code_valid;
  logic [EW-1:0] r_code;
  logic [3:0]    r_code_len;
  logic          r_err;
  logic          r_timeout;

  logic [11:0] w_k;
  logic        w_any;
  logic        w_one;
  logic        w_evt;
  logic        w_acc;
  logic [3:0]  w_code;
  logic        w_dig;
  logic        w_star;
  logic        w_hash;
  logic        w_take;
  logic        w_full;
  logic        w_exp;

  assign w_k   = {hash, asterisk, numbers};
  assign w_any = |w_k;
  // exactly one bit set: clearing the lowest set bit leaves nothing
  assign w_one = w_any && ((w_k & (w_k - 12'd1)) == 12'd0);
  assign w_evt = (r_state == S_REL) && w_one;
  assign w_acc = w_evt && en;

  always_comb begin
    w_code = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (w_k[i]) w_code = 4'(i);
    end
  end

  assign w_dig  = (w_code < 4'd10);
  assign w_star = (w_code == 4'd10);
  assign w_hash = (w_code == 4'd11);
  assign w_take = r_code_valid && code_ready;
  assign w_full = (r_len == 4'(DIGITS));
  // a key event on the expiry edge takes priority over the timer
  assign w_exp  = TEN && !w_evt && (r_len != 4'd0) &&
                  (r_cnt == TLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_REL;
    end else begin
      case (r_state)
        S_REL: begin
          if (w_one)      r_state <= S_PRS;
          else if (w_any) r_state <= S_INV;
        end
        S_PRS, S_INV: begin
          if (!w_any) r_state <= S_REL;
        end
        default: r_state <= S_REL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 24'd0;
    end else if (!TEN || w_evt || (r_len == 4'd0) || w_exp) begin
      r_cnt <= 24'd0;
    end else begin
      r_cnt <= r_cnt + 24'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_pulse  <= 1'b0;
      r_key_code   <= 4'd0;
      r_entry      <= '0;
      r_len        <= 4'd0;
      r_code_valid <= 1'b0;
      r_code       <= '0;
      r_code_len   <= 4'd0;
      r_err        <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_key_pulse <= w_acc;
      r_err       <= 1'b0;
      r_timeout   <= 1'b0;
      if (w_take) r_code_valid <= 1'b0;
      if (w_acc) begin
        r_key_code <= w_code;
        unique case (1'b1)
          w_dig: begin
            if (!w_full) begin
              r_entry <= (r_entry << 4) | EW'(w_code);
              r_len   <= r_len + 4'd1;
            end else begin
              r_err <= 1'b1;
            end
          end
          w_star: begin
            if (r_len != 4'd0) begin
              r_entry <= r_entry >> 4;
              r_len   <= r_len - 4'd1;
            end
          end
          w_hash: begin
            if (r_len == 4'd0) begin
              r_err <= 1'b1;
            end else if (r_code_valid && !code_ready) begin
              r_err <= 1'b1;
            end else begin
              r_code       <= r_entry;
              r_code_len   <= r_len;
              r_code_valid <= 1'b1;
              r_entry      <= '0;
              r_len        <= 4'd0;
            end
          end
          default: ;
        endcase
      end else if (w_exp) begin
        r_entry   <= '0;
        r_len     <= 4'd0;
        r_timeout <= 1'b1;
      end
    end
  end

  assign key_pulse  = r_key_pulse;
  assign key_code   = r_key_code;
  assign entry      = r_entry;
  assign entry_len  = r_len;
  assign code_valid = r_code_valid;
  assign code       = r_code;
  assign code_len   = r_code_len;
  assign err        = r_err;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: one instance with the timer off,
// one with TIMEOUT=100, both driven by the same key levels.
module tb_keypad_entry;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [9:0]  numbers;
  logic        asterisk;
  logic        hash;
  logic        code_ready;

  logic        key_pulse;
  logic [3:0]  key_code;
  logic [15:0] entry;
  logic [3:0]  entry_len;
  logic        code_valid;
  logic [15:0] code;
  logic [3:0]  code_len;
  logic        err;
  logic        timeout;

  logic        t_key_pulse;
  logic [3:0]  t_key_code;
  logic [15:0] t_entry;
  logic [3:0]  t_entry_len;
  logic        t_code_valid;
  logic [15:0] t_code;
  logic [3:0]  t_code_len;
  logic        t_err;
  logic        t_timeout;

  int n_cmp;
  int n_bad;

  keypad_entry #(.DIGITS(4), .TIMEOUT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .numbers(numbers), .asterisk(asterisk), .hash(hash),
    .key_pulse(key_pulse), .key_code(key_code),
    .entry(entry), .entry_len(entry_len),
    .code_valid(code_valid), .code_ready(code_ready),
    .code(code), .code_len(code_len),
    .err(err), .timeout(timeout)
  );

  keypad_entry #(.DIGITS(4), .TIMEOUT(100)) u_tmo (
    .clk(clk), .rst_n(rst_n), .en(en),
    .numbers(numbers), .asterisk(asterisk), .hash(hash),
    .key_pulse(t_key_pulse), .key_code(t_key_code),
    .entry(t_entry), .entry_len(t_entry_len),
    .code_valid(t_code_valid), .code_ready(code_ready),
    .code(t_code), .code_len(t_code_len),
    .err(t_err), .timeout(t_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [11:0] kv);
    {hash, asterisk, numbers} = kv;
    tick();
  endtask

  function automatic logic [11:0] kb(input int c);
    logic [11:0] v;
    v = 12'd1 << c;
    return v;
  endfunction

  // press, check pulse and code on the event edge, then release
  task automatic press(input int c);
    key(kb(c));
    check($sformatf("pulse_%0d", c), 64'(key_pulse), 64'd1);
    check($sformatf("kcode_%0d", c), 64'(key_code), 64'(c));
    key(12'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    en = 1'b1;
    code_ready = 1'b0;
    {hash, asterisk, numbers} = 12'd0;
    tick();
    tick();
    check("rst_outs",
          64'({key_pulse, key_code, entry, entry_len, code_valid,
               code, code_len, err, timeout}), 64'd0);
    rst_n = 1'b1;
    tick();

    // T1
    key(kb(1));
    check("t1_pulse1", 64'(key_pulse), 64'd1);
    check("t1_code1", 64'(key_code), 64'd1);
    key(12'd0);
    check("t1_pulse_one_cycle", 64'(key_pulse), 64'd0);
    press(2);
    press(3);
    check("t1_entry", 64'(entry), 64'h0123);
    check("t1_len", 64'(entry_len), 64'd3);
    key(kb(11));
    check("t1_code", 64'(code), 64'h0123);
    check("t1_code_len", 64'(code_len), 64'd3);
    check("t1_valid", 64'(code_valid), 64'd1);
    check("t1_entry_len0", 64'(entry_len), 64'd0);
    check("t1_entry0", 64'(entry), 64'd0);
    key(12'd0);
    check("t1_valid_held", 64'(code_valid), 64'd1);
    code_ready = 1'b1;
    tick();
    code_ready = 1'b0;
    check("t1_taken", 64'(code_valid), 64'd0);

    // T2
    press(7);
    key(kb(11));
    check("t2_valid7", 64'(code_valid), 64'd1);
    check("t2_code7", 64'(code), 64'h0007);
    check("t2_err_ok", 64'(err), 64'd0);
    key(12'd0);
    press(8);
    key(kb(11));
    check("t2_busy_err", 64'(err), 64'd1);
    check("t2_entry_kept", 64'(entry), 64'h0008);
    check("t2_len_kept", 64'(entry_len), 64'd1);
    check("t2_code_stable", 64'(code), 64'h0007);
    key(12'd0);
    check("t2_err_one_cycle", 64'(err), 64'd0);
    code_ready = 1'b1;
    tick();
    code_ready = 1'b0;
    check("t2_valid_fall", 64'(code_valid), 64'd0);
    check("t2_code_after", 64'(code), 64'h0007);
    key(kb(11));
    check("t2_commit8", 64'(code), 64'h0008);
    check("t2_commit8_v", 64'(code_valid), 64'd1);
    key(12'd0);
    press(9);
    // '#' on the same edge as the take is accepted
    code_ready = 1'b1;
    key(kb(11));
    code_ready = 1'b0;
    check("t2_same_edge_err", 64'(err), 64'd0);
    check("t2_same_edge_code", 64'(code), 64'h0009);
    check("t2_same_edge_v", 64'(code_valid), 64'd1);
    check("t2_same_edge_len", 64'(code_len), 64'd1);
    key(12'd0);
    code_ready = 1'b1;
    tick();
    code_ready = 1'b0;
    check("t2_final_take", 64'(code_valid), 64'd0);

    // T3
    press(5);
    press(6);
    press(7);
    press(8);
    key(kb(9));
    check("t3_full_err", 64'(err), 64'd1);
    check("t3_full_entry", 64'(entry), 64'h5678);
    check("t3_full_len", 64'(entry_len), 64'd4);
    key(12'd0);
    key(kb(10));
    check("t3_del1", 64'(entry), 64'h0567);
    key(12'd0);
    key(kb(10));
    check("t3_del2", 64'(entry), 64'h0056);
    key(12'd0);
    key(kb(10));
    check("t3_del3", 64'(entry), 64'h0005);
    key(12'd0);
    key(kb(10));
    check("t3_del4", 64'(entry), 64'h0000);
    check("t3_del4_len", 64'(entry_len), 64'd0);
    key(12'd0);
    key(kb(10));
    check("t3_del_empty_err", 64'(err), 64'd0);
    check("t3_del_empty_pulse", 64'(key_pulse), 64'd1);
    check("t3_del_empty_code", 64'(key_code), 64'd10);
    key(12'd0);
    key(kb(11));
    check("t3_hash_empty_err", 64'(err), 64'd1);
    check("t3_hash_empty_v", 64'(code_valid), 64'd0);
    key(12'd0);

    // T4
    key(kb(3) | kb(4));
    check("t4_multi_pulse", 64'(key_pulse), 64'd0);
    check("t4_multi_err", 64'(err), 64'd0);
    key(kb(3) | kb(4));
    check("t4_multi_hold", 64'(key_pulse), 64'd0);
    key(kb(4));
    check("t4_drop_to_one", 64'(key_pulse), 64'd0);
    key(12'd0);
    key(kb(4));
    check("t4_pulse4", 64'(key_pulse), 64'd1);
    check("t4_code4", 64'(key_code), 64'd4);
    key(kb(4) | kb(9));
    check("t4_add9", 64'(key_pulse), 64'd0);
    check("t4_entry", 64'(entry), 64'h0004);
    key(12'd0);
    press(10);
    check("t4_cleared", 64'(entry_len), 64'd0);

    // T5: timer instance
    check("t5_start_len", 64'(t_entry_len), 64'd0);
    key(kb(2));
    check("t5_len1", 64'(t_entry_len), 64'd1);
    key(12'd0);
    repeat (98) tick();
    check("t5_no_timeout_yet", 64'(t_timeout), 64'd0);
    check("t5_len_before", 64'(t_entry_len), 64'd1);
    tick();
    check("t5_timeout", 64'(t_timeout), 64'd1);
    check("t5_len_after", 64'(t_entry_len), 64'd0);
    check("t5_entry_after", 64'(t_entry), 64'd0);
    check("t5_disabled", 64'({timeout, entry_len}), 64'h01);
    tick();
    check("t5_timeout_one", 64'(t_timeout), 64'd0);
    press(10);
    key(kb(2));
    key(12'd0);
    repeat (98) tick();
    key(kb(5));
    check("t5_race_timeout", 64'(t_timeout), 64'd0);
    check("t5_race_pulse", 64'(t_key_pulse), 64'd1);
    check("t5_race_entry", 64'(t_entry), 64'h0025);
    check("t5_race_len", 64'(t_entry_len), 64'd2);
    key(12'd0);

    // T6
    key(kb(11));
    check("t6_valid", 64'(code_valid), 64'd1);
    key(12'd0);
    press(3);
    check("t6_len", 64'(entry_len), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_rst",
          64'({key_pulse, key_code, entry, entry_len, code_valid,
               code, code_len, err, timeout}), 64'd0);
    check("t6_async_rst_t",
          64'({t_entry_len, t_code_valid, t_code}), 64'd0);
    tick();
    rst_n = 1'b1;
    en = 1'b0;
    key(kb(6));
    check("t6_en0_pulse", 64'(key_pulse), 64'd0);
    check("t6_en0_len", 64'(entry_len), 64'd0);
    en = 1'b1;
    key(kb(6));
    check("t6_held_pulse", 64'(key_pulse), 64'd0);
    key(12'd0);
    key(kb(6));
    check("t6_pulse6", 64'(key_pulse), 64'd1);
    check("t6_code6", 64'(key_code), 64'd6);
    check("t6_entry6", 64'(entry), 64'h0006);
    key(12'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
